// File: rtl/wb_sram_b3.sv
// Wishbone B3 slave front-end for a single-port synchronous SRAM with 1-cycle read latency.
// Define WB_SRAM_BURST_EN to build incrementing/wrapping burst support with read prefetch.
module wb_sram_b3 #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_SIZE_BYTES = 32768,
  localparam int SEL_WIDTH     = DATA_WIDTH / 8,
  localparam int SEL_BITS      = $clog2(SEL_WIDTH),
  localparam int MEM_AW        = $clog2(MEM_SIZE_BYTES / SEL_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [SEL_WIDTH-1:0]  sel_i,
  input  logic [2:0]            cti_i,
  input  logic [1:0]            bte_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  ack_o,
  output logic                  err_o,
  output logic                  rty_o,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [MEM_AW-1:0]     sram_adr,
  output logic [SEL_WIDTH-1:0]  sram_sel,
  output logic [DATA_WIDTH-1:0] sram_wdat,
  input  logic [DATA_WIDTH-1:0] sram_rdat
);

  typedef enum logic [1:0] {IDLE, SINGLE, BURST} state_t;

  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE_BYTES);

  state_t            state_reg, state_next;
  logic              ack_reg, ack_next;
  logic              err_reg, err_next;
  logic [MEM_AW-1:0] cur_adr_reg, cur_adr_next;
  logic [MEM_AW-1:0] word_idx;
  logic              req;
  logic              out_of_range;

  assign word_idx     = adr_i[MEM_AW+SEL_BITS-1:SEL_BITS];
  assign out_of_range = {1'b0, adr_i} >= MEM_LIMIT;
  assign req          = cyc_i & stb_i;

`ifdef WB_SRAM_BURST_EN
  logic [1:0]        bte_reg, bte_next;
  logic [MEM_AW-1:0] nxt_adr;
  logic              burst_go;

  // Wrapping bursts only advance the low address bits; upper bits stay put.
  always_comb begin
    nxt_adr = cur_adr_reg;
    case (bte_reg)
      2'b00:   nxt_adr      = cur_adr_reg + MEM_AW'(1);
      2'b01:   nxt_adr[1:0] = cur_adr_reg[1:0] + 2'd1;
      2'b10:   nxt_adr[2:0] = cur_adr_reg[2:0] + 3'd1;
      default: nxt_adr[3:0] = cur_adr_reg[3:0] + 4'd1;
    endcase
  end

  assign burst_go = req && (cti_i == 3'b010) && (bte_i == bte_reg);
`else
  logic unused_burst_inputs;
  assign unused_burst_inputs = ^{cti_i, bte_i};
`endif

  always_comb begin
    state_next   = state_reg;
    ack_next     = 1'b0;
    err_next     = 1'b0;
    cur_adr_next = cur_adr_reg;
`ifdef WB_SRAM_BURST_EN
    bte_next     = bte_reg;
`endif
    sram_ce      = 1'b0;
    sram_we      = 1'b0;
    sram_adr     = cur_adr_reg;
    case (state_reg)
      IDLE: begin
        if (req && !ack_reg && !err_reg) begin
          if (out_of_range) begin
            err_next = 1'b1;
          end else begin
            cur_adr_next = word_idx;
            ack_next     = 1'b1;
            sram_ce      = !we_i;
            sram_adr     = word_idx;
`ifdef WB_SRAM_BURST_EN
            if (cti_i == 3'b010) begin
              state_next = BURST;
              bte_next   = bte_i;
            end else begin
              state_next = SINGLE;
            end
`else
            state_next = SINGLE;
`endif
          end
        end
      end
      SINGLE: begin
        // Write lands in the ack cycle while dat_i/sel_i are still held.
        sram_ce    = req & we_i;
        sram_we    = req & we_i;
        state_next = IDLE;
      end
`ifdef WB_SRAM_BURST_EN
      BURST: begin
        sram_ce = req & we_i;
        sram_we = req & we_i;
        if (burst_go) begin
          cur_adr_next = nxt_adr;
          ack_next     = 1'b1;
          if (!we_i) begin
            sram_ce  = 1'b1;
            sram_adr = nxt_adr;
          end
        end else begin
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
    // An aborting reset must not leave a half-finished write behind.
    if (rst_i) begin
      sram_ce = 1'b0;
      sram_we = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      ack_reg     <= 1'b0;
      err_reg     <= 1'b0;
      cur_adr_reg <= '0;
`ifdef WB_SRAM_BURST_EN
      bte_reg     <= 2'b00;
`endif
    end else begin
      state_reg   <= state_next;
      ack_reg     <= ack_next;
      err_reg     <= err_next;
      cur_adr_reg <= cur_adr_next;
`ifdef WB_SRAM_BURST_EN
      bte_reg     <= bte_next;
`endif
    end
  end

  assign sram_sel  = sel_i;
  assign sram_wdat = dat_i;
  assign dat_o     = ack_reg ? sram_rdat : '0;
  assign ack_o     = ack_reg;
  assign err_o     = err_reg;
  assign rty_o     = 1'b0;

endmodule

// File: tb/tb_wb_sram_b3.sv
// Self-checking bench for wb_sram_b3: bench-side SRAM, golden word array and a
// Wishbone master whose expected ack latencies come from the protocol rules.
module tb_wb_sram_b3;

`ifdef WB_SRAM_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif
  localparam int WORDS = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0, dat = '0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;
  logic [31:0] dat_o;
  logic        ack_o, err_o, rty_o;
  logic        sram_ce, sram_we;
  logic [12:0] sram_adr;
  logic [3:0]  sram_sel;
  logic [31:0] sram_wdat, sram_rdat;

  logic [31:0] mem  [WORDS];
  logic [31:0] gold [WORDS];
  logic [31:0] rd_q [$];

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  bit chk_live = 1'b0;
  bit oor_live = 1'b0;
  int chk_word = 0;

  always #5 clk = ~clk;

  wb_sram_b3 dut (
    .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(dat),
    .cyc_i(cyc), .stb_i(stb), .we_i(we), .sel_i(sel),
    .cti_i(cti), .bte_i(bte), .dat_o(dat_o), .ack_o(ack_o),
    .err_o(err_o), .rty_o(rty_o), .sram_ce(sram_ce), .sram_we(sram_we),
    .sram_adr(sram_adr), .sram_sel(sram_sel), .sram_wdat(sram_wdat),
    .sram_rdat(sram_rdat)
  );

  // Synchronous SRAM: byte-lane writes, registered read.
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) begin
        for (int i = 0; i < 4; i++)
          if (sram_sel[i]) mem[sram_adr][i*8 +: 8] <= sram_wdat[i*8 +: 8];
      end else begin
        sram_rdat <= mem[sram_adr];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int nxt_word(input int w, input logic [1:0] b);
    int len;
    if (b == 2'b00) return (w + 1) % WORDS;
    len = 2 << b;
    return (w / len) * len + (w % len + 1) % len;
  endfunction

  // Per-cycle compare against the golden memory and protocol invariants.
  always @(negedge clk) begin
    if (mon_en) begin
      check("rty_zero", rty_o, 0);
      check("ack_err_excl", ack_o & err_o, 0);
      if (!ack_o) begin
        check("dat_idle", dat_o, 0);
        check("we_idle", sram_we, 0);
      end
      if (oor_live) check("oor_ce", sram_ce, 0);
      if (chk_live && !rst && cyc && stb && ack_o) begin
        if (!we) begin
          check("rd_data", dat_o, gold[chk_word]);
        end else begin
          check("wr_en", {sram_ce, sram_we}, 2'b11);
          check("wr_adr", sram_adr, chk_word);
          check("wr_dat", sram_wdat, dat);
          check("wr_sel", sram_sel, sel);
        end
      end
    end
  end

  // One Wishbone beat: hold it until ack/err, check termination kind and wait count.
  task automatic beat(input logic [31:0] a, input bit w, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] c, input logic [1:0] b,
                      input int exp_waits, input bit exp_err, output logic [31:0] rdata);
    int  waits = 0;
    bit  done  = 1'b0;
    cyc = 1'b1; stb = 1'b1; adr = a; we = w; dat = d; sel = s; cti = c; bte = b;
    chk_word = int'(a[14:2]);
    chk_live = !exp_err;
    oor_live = exp_err;
    rdata = '0;
    while (!done) begin
      @(negedge clk);
      if (ack_o || err_o) begin
        check("term_err", err_o, exp_err);
        check("term_ack", ack_o, !exp_err);
        check("waits", waits, exp_waits);
        rdata = dat_o;
        @(posedge clk); #1;
        if (w && !exp_err)
          for (int i = 0; i < 4; i++)
            if (s[i]) gold[chk_word][i*8 +: 8] = d[i*8 +: 8];
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 6) begin
          check("beat_timeout", 1, 0);
          done = 1'b1;
        end
        @(posedge clk); #1;
      end
    end
    chk_live = 1'b0;
    oor_live = 1'b0;
  endtask

  task automatic idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    @(negedge clk);
    check("idle_ack", {ack_o, err_o}, 2'b00);
    @(posedge clk); #1;
  endtask

  // Burst of len beats, optionally dropping stb for 2 cycles after beat gap_after.
  task automatic burst(input int start_w, input int len, input bit w, input logic [1:0] b,
                       input int gap_after, input bit rnd);
    int          wd = start_w;
    bit          gapped = 1'b0;
    logic [31:0] r, d;
    logic [3:0]  s;
    logic [2:0]  c;
    s = rnd ? 4'($urandom) : 4'hF;
    rd_q.delete();
    for (int k = 0; k < len; k++) begin
      c = (k == len - 1) ? 3'b111 : 3'b010;
      d = rnd ? $urandom : 32'h5500_0000 + 32'(k);
      beat(32'(wd << 2), w, d, s, c, b, (BURST_EN && k > 0 && !gapped) ? 0 : 1, 1'b0, r);
      rd_q.push_back(r);
      gapped = 1'b0;
      if (k == gap_after) begin
        stb = 1'b0;
        for (int i = 0; i < 2; i++) begin
          @(negedge clk);
          check("gap_ack", ack_o, BURST_EN && i == 0);
          @(posedge clk); #1;
        end
        gapped = 1'b1;
      end
      wd = nxt_word(wd, b);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] exp_w4 [4];
    bit          found;
    int          w, len, kind;
    logic [1:0]  b;
    exp_w4 = '{32'hA000_000E, 32'hA000_000F, 32'hA000_000C, 32'hA000_000D};
    for (int i = 0; i < WORDS; i++) begin
      mem[i]  = 32'hA000_0000 | i;
      gold[i] = 32'hA000_0000 | i;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", ack_o, 0);
    check("rst_err", err_o, 0);
    check("rst_ce", sram_ce, 0);
    check("rst_we", sram_we, 0);
    check("rst_dat", dat_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    beat(32'h10, 1, 32'hDEAD_BEEF, 4'hF, 3'b000, 2'b00, 1, 0, r);
    idle();
    beat(32'h10, 0, 0, 4'hF, 3'b000, 2'b00, 1, 0, r);
    check("rd_deadbeef", r, 32'hDEAD_BEEF);
    idle();
    beat(32'h10, 1, 32'h00AB_0000, 4'b0100, 3'b000, 2'b00, 1, 0, r);
    beat(32'h10, 0, 0, 4'hF, 3'b000, 2'b00, 1, 0, r);
    check("rd_byte_merge", r, 32'hDEAB_BEEF);
    idle();

    burst(8, 4, 0, 2'b00, -1, 0);
    for (int i = 0; i < 4; i++) check("incr_word", rd_q[i], 32'hA000_0008 + 32'(i));
    idle();
    burst(14, 4, 0, 2'b01, -1, 0);
    for (int i = 0; i < 4; i++) check("wrap4_word", rd_q[i], exp_w4[i]);
    idle();
    burst(6, 8, 1, 2'b10, -1, 0);
    idle();
    beat(32'h18, 0, 0, 4'hF, 3'b000, 2'b00, 1, 0, r);
    check("wrap8_w6", r, 32'h5500_0000);
    beat(32'h00, 0, 0, 4'hF, 3'b000, 2'b00, 1, 0, r);
    check("wrap8_w0", r, 32'h5500_0002);
    beat(32'h14, 0, 0, 4'hF, 3'b000, 2'b00, 1, 0, r);
    check("wrap8_w5", r, 32'h5500_0007);
    idle();

    beat(32'h8000, 0, 0, 4'hF, 3'b000, 2'b00, 1, 1, r);
    idle();

    burst(40, 6, 0, 2'b00, 1, 0);
    check("gap_resume_word", rd_q[2], 32'hA000_002A);
    check("gap_last_word", rd_q[5], 32'hA000_002D);
    idle();

    // Reset during the second beat of a write burst.
    beat(32'(100 << 2), 1, 32'h1111_1111, 4'hF, 3'b010, 2'b00, 1, 0, r);
    adr = 32'(101 << 2); dat = 32'h2222_2222;
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      @(negedge clk);
      if (ack_o) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("rst_mid_ack_seen", found, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_we", sram_we, 0);
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    check("rst_mid_ack_after", ack_o, 0);
    check("rst_mid_we_after", sram_we, 0);
    @(posedge clk); #1;
    beat(32'(101 << 2), 0, 0, 4'hF, 3'b000, 2'b00, 1, 0, r);
    check("rst_no_write", r, 32'hA000_0065);
    beat(32'(100 << 2), 0, 0, 4'hF, 3'b000, 2'b00, 1, 0, r);
    check("rst_prev_write", r, 32'h1111_1111);
    idle();

    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 3);
      w = $urandom_range(0, WORDS - 1);
      b = 2'($urandom);
      case (kind)
        0: beat(32'(w << 2), 0, 0, 4'hF, 3'b000, b, 1, 0, r);
        1: beat(32'(w << 2), 1, $urandom, 4'($urandom), 3'b000, b, 1, 0, r);
        2: beat(32'h8000 | ($urandom & 32'hFFFF_FFFC), 1'($urandom), $urandom, 4'hF,
                3'b000, 2'b00, 1, 1, r);
        default: begin
          len = $urandom_range(1, 8);
          if (b == 2'b00) w = $urandom_range(0, WORDS - 9);
          burst(w, len, 1'($urandom),
                b, (len >= 2 && $urandom_range(0, 2) == 0) ? $urandom_range(0, len - 2) : -1, 1);
        end
      endcase
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
